// File: rtl/sram_ctrl.sv
// Two-port controller for an asynchronous 64K x 32 SRAM with registered strobes.
// Define SRAM_CTRL_ROUND_ROBIN_EN for round-robin arbitration (default: port B priority).
module sram_ctrl #(
  parameter int RD_CYCLES = 2,
  parameter int WE_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        N_RST,
  input  logic        A_REQ,
  input  logic [15:0] A_ADDR,
  output logic        A_ACK,
  input  logic        B_REQ,
  input  logic        B_WE,
  input  logic [15:0] B_ADDR,
  input  logic [31:0] B_WDATA,
  output logic        B_ACK,
  output logic [31:0] RDATA,
  output logic        BUSY,
  output logic [15:0] SRAM_ADDR,
  output logic [31:0] SRAM_WDATA,
  output logic        SRAM_N_OE,
  output logic        SRAM_N_WE,
  input  logic [31:0] SRAM_RDATA
);

  localparam int MAXC = (RD_CYCLES > WE_CYCLES) ? RD_CYCLES : WE_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_b_q, sel_b_d;
  logic          a_ack_q, a_ack_d;
  logic          b_ack_q, b_ack_d;
  logic          busy_q, busy_d;
  logic          n_oe_q, n_oe_d;
  logic          n_we_q, n_we_d;
  logic [15:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;

  logic elig_a, elig_b, pick_b, grant;

`ifdef SRAM_CTRL_ROUND_ROBIN_EN
  // 1 = port B was granted last
  logic ptr_q, ptr_d;
`endif

  // A port whose ACK is high this cycle is not re-sampled
  always_comb begin
    elig_a = A_REQ && !a_ack_q;
    elig_b = B_REQ && !b_ack_q;
    grant  = elig_a || elig_b;
`ifdef SRAM_CTRL_ROUND_ROBIN_EN
    pick_b = elig_b && (!elig_a || !ptr_q);
`else
    pick_b = elig_b;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_b_d = sel_b_q;
    a_ack_d = 1'b0;
    b_ack_d = 1'b0;
    n_oe_d  = n_oe_q;
    n_we_d  = n_we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef SRAM_CTRL_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          sel_b_d = pick_b;
          addr_d  = pick_b ? B_ADDR : A_ADDR;
`ifdef SRAM_CTRL_ROUND_ROBIN_EN
          ptr_d   = pick_b;
`endif
          if (pick_b && B_WE) begin
            wdata_d = B_WDATA;
            state_d = WR_SETUP;
          end else begin
            n_oe_d  = 1'b0;
            cnt_d   = CW'(RD_CYCLES - 1);
            state_d = RD;
          end
        end
      end
      RD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          rdata_d = SRAM_RDATA;
          n_oe_d  = 1'b1;
          a_ack_d = !sel_b_q;
          b_ack_d = sel_b_q;
          state_d = IDLE;
        end
      end
      WR_SETUP: begin
        n_we_d  = 1'b0;
        cnt_d   = CW'(WE_CYCLES - 1);
        state_d = WR_STROBE;
      end
      WR_STROBE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          n_we_d  = 1'b1;
          state_d = WR_HOLD;
        end
      end
      WR_HOLD: begin
        a_ack_d = !sel_b_q;
        b_ack_d = sel_b_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!N_RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_b_q <= 1'b0;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      busy_q  <= 1'b0;
      n_oe_q  <= 1'b1;
      n_we_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef SRAM_CTRL_ROUND_ROBIN_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_b_q <= sel_b_d;
      a_ack_q <= a_ack_d;
      b_ack_q <= b_ack_d;
      busy_q  <= busy_d;
      n_oe_q  <= n_oe_d;
      n_we_q  <= n_we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef SRAM_CTRL_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign A_ACK      = a_ack_q;
  assign B_ACK      = b_ack_q;
  assign RDATA      = rdata_q;
  assign BUSY       = busy_q;
  assign SRAM_ADDR  = addr_q;
  assign SRAM_WDATA = wdata_q;
  assign SRAM_N_OE  = n_oe_q;
  assign SRAM_N_WE  = n_we_q;

endmodule
